// File: rtl/spi_pkg_tx_if.sv
// spi_pkg_tx_if: FIFO-side and SPI-side signals of the packet transmitter
interface spi_pkg_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH = 13
);
  logic                  package_ready;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_valid;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic                  intr_out;
  logic                  spi_cs_n;
  logic                  spi_sck;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic [CNT_WIDTH-1:0]  byte_cnt;
  logic                  pkg_done;
  logic                  underrun;
  modport master (
    output package_ready, fifo_dout, fifo_valid, fifo_empty, spi_cs_n, spi_sck,
    input  fifo_rd_en, intr_out, spi_miso, spi_miso_oe, byte_cnt, pkg_done, underrun
  );
  modport slave (
    input  package_ready, fifo_dout, fifo_valid, fifo_empty, spi_cs_n, spi_sck,
    output fifo_rd_en, intr_out, spi_miso, spi_miso_oe, byte_cnt, pkg_done, underrun
  );
endinterface

// File: rtl/spi_pkg_tx.sv
// spi_pkg_tx: SPI-slave transmitter serving one prefetched FIFO package per host interrupt
module spi_pkg_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PKG_BYTES = 4864,
  parameter int CNT_WIDTH = 13
) (
  input logic         sys_clk,
  input logic         rst_n,
  spi_pkg_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, ARMED, XFER, DONE} state_e;
  localparam logic [CNT_WIDTH-1:0] PKG = CNT_WIDTH'(PKG_BYTES);
  localparam logic [2:0] LAST = 3'(DATA_WIDTH - 1);
  state_e                state_q;
  logic [2:0]            cs_q, sck_q, bit_q;
  logic [DATA_WIDTH-1:0] cur_q, hold_q;
  logic [CNT_WIDTH-1:0]  fetch_q, byte_q;
  logic                  hold_full_q, got_q, reload_q, pend_q, rd_q, intr_q, done_q, under_q;
  logic                  cs_fall, cs_rise, sck_rise, sck_fall, act, fetch_ok, issue, reload;
  assign cs_fall  = cs_q[2] & ~cs_q[1];
  assign cs_rise  = ~cs_q[2] & cs_q[1];
  assign sck_rise = ~sck_q[2] & sck_q[1];
  assign sck_fall = sck_q[2] & ~sck_q[1];
  assign act      = state_q == ARMED || state_q == XFER;
  // only one read may be outstanding, and only into an empty hold register
  assign fetch_ok = !hold_full_q && !pend_q && fetch_q != PKG && !bus.fifo_empty;
  assign issue    = fetch_ok && (act || (state_q == LOAD && got_q));
  assign reload   = state_q == XFER && reload_q && (sck_fall || cs_rise);
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cs_q        <= '1;
      sck_q       <= '0;
      bit_q       <= '0;
      cur_q       <= '0;
      hold_q      <= '0;
      fetch_q     <= '0;
      byte_q      <= '0;
      hold_full_q <= 1'b0;
      got_q       <= 1'b0;
      reload_q    <= 1'b0;
      pend_q      <= 1'b0;
      rd_q        <= 1'b0;
      intr_q      <= 1'b0;
      done_q      <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      cs_q   <= {cs_q[1:0], bus.spi_cs_n};
      sck_q  <= {sck_q[1:0], bus.spi_sck};
      rd_q   <= issue;
      done_q <= 1'b0;
      if (issue) begin
        pend_q  <= 1'b1;
        fetch_q <= fetch_q + 1'b1;
      end
      case (state_q)
        IDLE: if (bus.package_ready && !bus.fifo_empty) begin
          rd_q    <= 1'b1;
          pend_q  <= 1'b1;
          fetch_q <= fetch_q + 1'b1;
          state_q <= LOAD;
        end
        LOAD: if (got_q) begin
          got_q   <= 1'b0;
          intr_q  <= 1'b1;
          state_q <= ARMED;
        end else if (bus.fifo_valid && pend_q) begin
          got_q <= 1'b1;
          bit_q <= '0;
        end
        ARMED: if (cs_fall) state_q <= XFER;
        XFER: if (cs_rise) begin
          bit_q   <= '0;
          state_q <= ARMED;
        end else if (sck_rise && bit_q == LAST) begin
          byte_q   <= byte_q + 1'b1;
          reload_q <= byte_q != PKG - 1'b1;
          done_q   <= byte_q == PKG - 1'b1;
          intr_q   <= byte_q != PKG - 1'b1;
          state_q  <= byte_q == PKG - 1'b1 ? DONE : XFER;
        end else if (sck_fall && !reload_q) bit_q <= bit_q + 1'b1;
        DONE: if (cs_q[1]) begin
          byte_q      <= '0;
          fetch_q     <= '0;
          hold_full_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // an empty hold register at reload time sends a zero byte and flags underrun
      if (reload) begin
        reload_q    <= 1'b0;
        bit_q       <= '0;
        hold_full_q <= 1'b0;
        cur_q       <= hold_full_q ? hold_q : '0;
        under_q     <= under_q | !hold_full_q;
      end
      if (bus.fifo_valid && pend_q) begin
        pend_q <= 1'b0;
        if (state_q == LOAD) cur_q <= bus.fifo_dout;
        else begin
          hold_q      <= bus.fifo_dout;
          hold_full_q <= 1'b1;
        end
      end
    end
  end
  assign bus.fifo_rd_en  = rd_q;
  assign bus.intr_out    = intr_q;
  assign bus.spi_miso    = act & cur_q[LAST - bit_q];
  assign bus.spi_miso_oe = act & ~cs_q[1];
  assign bus.byte_cnt    = byte_q;
  assign bus.pkg_done    = done_q;
  assign bus.underrun    = under_q;
endmodule

// File: tb/tb_spi_pkg_tx.sv
// tb_spi_pkg_tx: scoreboard bench driving a FIFO model and a mode-0 SPI host at sys_clk/8
module tb_spi_pkg_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_pkg_tx_if #(.DATA_WIDTH(8), .CNT_WIDTH(13)) bus ();
  spi_pkg_tx #(.DATA_WIDTH(8), .PKG_BYTES(4), .CNT_WIDTH(13)) dut (.sys_clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, failures = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int rd_count = 0, done_cnt = 0, max_bc = 0, slow_idx = -1, slow_delay = 0;
  logic [7:0] b;
  int rd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) fifo_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic push_exp(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    bus.spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic sck_bits(input int n, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      repeat (4) @(negedge clk);
      r = {r[6:0], bus.spi_miso};
      bus.spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      bus.spi_sck = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic host_byte(input string tag);
    logic [7:0] r, e;
    sck_bits(8, r);
    e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
    check(tag, r, e);
  endtask

  task automatic wait_intr(input logic lvl, input string tag);
    int n = 0;
    while (bus.intr_out !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.intr_out, lvl);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd_en"}, bus.fifo_rd_en, 0);
    check({tag, "_intr"}, bus.intr_out, 0);
    check({tag, "_miso"}, bus.spi_miso, 0);
    check({tag, "_oe"}, bus.spi_miso_oe, 0);
    check({tag, "_byte_cnt"}, bus.byte_cnt, 0);
    check({tag, "_pkg_done"}, bus.pkg_done, 0);
    check({tag, "_underrun"}, bus.underrun, 0);
  endtask

  initial begin
    bus.fifo_valid = 1'b0;
    bus.fifo_dout = '0;
    bus.fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      bus.fifo_empty = fifo_q.size() == 0;
      if (bus.fifo_rd_en === 1'b1) begin
        rd_count++;
        if (rd_count == slow_idx) repeat (slow_delay) @(negedge clk);
        @(negedge clk);
        bus.fifo_dout = fifo_q.size() != 0 ? fifo_q.pop_front() : 8'h00;
        bus.fifo_valid = 1'b1;
        bus.fifo_empty = fifo_q.size() == 0;
        @(negedge clk);
        bus.fifo_valid = 1'b0;
      end
    end
  end

  always @(posedge clk) if (rst_n && bus.pkg_done) done_cnt <= done_cnt + 1;
  always @(negedge clk) if (int'(bus.byte_cnt) > max_bc) max_bc <= int'(bus.byte_cnt);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.spi_cs_n = 1'b1;
    bus.spi_sck = 1'b0;
    bus.package_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    fill(32'hA53CFF01);
    push_exp(32'hA53CFF01);
    bus.package_ready = 1'b1;
    wait_intr(1'b1, "p1_intr_rise");
    bus.package_ready = 1'b0;
    check("p1_oe_cs_high", bus.spi_miso_oe, 0);
    cs_low();
    check("p1_oe_cs_low", bus.spi_miso_oe, 1);
    repeat (4) host_byte("p1_byte");
    repeat (4) @(negedge clk);
    check("p1_pkg_done", done_cnt, 1);
    check("p1_intr_low", bus.intr_out, 0);
    check("p1_byte_cnt", bus.byte_cnt, 4);
    check("p1_reads", rd_count, 4);
    sck_bits(3, b);
    check("p1_extra_miso", b, 0);
    check("p1_extra_cnt", bus.byte_cnt, 4);
    check("p1_extra_done", done_cnt, 1);
    cs_high();
    check("p1_cnt_clear", bus.byte_cnt, 0);
    check("p1_no_underrun", bus.underrun, 0);

    fill(32'hA53CFF01);
    push_exp(32'hA53CFF01);
    bus.package_ready = 1'b1;
    wait_intr(1'b1, "ab_intr_rise");
    bus.package_ready = 1'b0;
    cs_low();
    host_byte("ab_byte1");
    sck_bits(3, b);
    check("ab_partial", b, 1);
    cs_high();
    check("ab_cnt_hold", bus.byte_cnt, 1);
    check("ab_intr_hold", bus.intr_out, 1);
    sck_bits(4, b);
    check("ab_sck_cs_high", bus.byte_cnt, 1);
    cs_low();
    repeat (3) host_byte("ab_byte");
    repeat (4) @(negedge clk);
    check("ab_pkg_done", done_cnt, 2);
    check("ab_byte_cnt", bus.byte_cnt, 4);
    cs_high();

    rd0 = rd_count;
    fill(32'hA53CFF01);
    fill(32'h11223344);
    push_exp(32'hA53CFF01);
    bus.package_ready = 1'b1;
    wait_intr(1'b1, "bb_intr1");
    cs_low();
    repeat (4) host_byte("bb_pkg1");
    repeat (4) @(negedge clk);
    check("bb_reads1", rd_count - rd0, 4);
    check("bb_intr_low", bus.intr_out, 0);
    push_exp(32'h11223344);
    cs_high();
    wait_intr(1'b1, "bb_intr2");
    bus.package_ready = 1'b0;
    cs_low();
    repeat (4) host_byte("bb_pkg2");
    repeat (4) @(negedge clk);
    check("bb_reads2", rd_count - rd0, 8);
    check("bb_pkg_done", done_cnt, 4);
    cs_high();

    fill(32'hA53CFF01);
    push_exp(32'hA5003CFF);
    slow_idx = rd_count + 2;
    slow_delay = 100;
    bus.package_ready = 1'b1;
    wait_intr(1'b1, "ur_intr");
    bus.package_ready = 1'b0;
    cs_low();
    repeat (4) host_byte("ur_byte");
    repeat (4) @(negedge clk);
    check("ur_flag", bus.underrun, 1);
    check("ur_byte_cnt", bus.byte_cnt, 4);
    check("ur_pkg_done", done_cnt, 5);
    cs_high();
    check("ur_sticky", bus.underrun, 1);
    slow_idx = -1;

    fill(32'h5A5A5A5A);
    bus.package_ready = 1'b1;
    wait_intr(1'b1, "rs_intr");
    bus.package_ready = 1'b0;
    cs_low();
    sck_bits(5, b);
    rst_n = 1'b0;
    #1;
    check_reset("rs_async");
    bus.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rs_intr_low", bus.intr_out, 0);
    check("rs_rd_idle", bus.fifo_rd_en, 0);
    bus.package_ready = 1'b1;
    wait_intr(1'b1, "rs_restart");
    bus.package_ready = 1'b0;
    check("byte_cnt_max", max_bc, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
